// File: rtl/mult_scheduler.sv
// Two-requester round-robin front end for one shared 3x3 multiplier, one transaction in flight.
// Optional macro MULT_SCHED_ZERO_BYPASS_EN: a zero operand skips the multiply cycle.
module mult_scheduler #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [2:0]       req0_a,
  input  logic [2:0]       req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [2:0]       req1_a,
  input  logic [2:0]       req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [5:0]       rsp_p,
  output logic             rsp_id,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  state_t           state_q;
  logic             last_q;
  logic [2:0]       a_q;
  logic [2:0]       b_q;
  logic             id_q;
  logic             rsp_valid_q;
  logic [5:0]       rsp_p_q;
  logic             rsp_id_q;
  logic [CNT_W-1:0] op_count_q;

  logic       grant0;
  logic       grant1;
  logic [2:0] sel_a;
  logic [2:0] sel_b;
  logic       zero_op;

  // last_q==1 means requester 1 was served most recently, so requester 0 wins a tie.
  assign grant0 = !rst && (state_q == IDLE) && req0_valid && (!req1_valid || last_q);
  assign grant1 = !rst && (state_q == IDLE) && req1_valid && (!req0_valid || !last_q);
  assign sel_a  = grant1 ? req1_a : req0_a;
  assign sel_b  = grant1 ? req1_b : req0_b;

`ifdef MULT_SCHED_ZERO_BYPASS_EN
  assign zero_op = (sel_a == 3'd0) || (sel_b == 3'd0);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_p_q     <= '0;
      rsp_id_q    <= 1'b0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            a_q    <= sel_a;
            b_q    <= sel_b;
            id_q   <= grant1;
            last_q <= grant1;
            if (zero_op) begin
              rsp_p_q     <= '0;
              rsp_id_q    <= grant1;
              rsp_valid_q <= 1'b1;
              state_q     <= HOLD;
            end else begin
              state_q <= MUL;
            end
          end
        end
        MUL: begin
          rsp_p_q     <= {3'b000, a_q} * {3'b000, b_q};
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + CNT_W'(1);
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_p      = rsp_p_q;
  assign rsp_id     = rsp_id_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_mult_scheduler.sv
// Bench for mult_scheduler: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations; a CNT_W=2 copy checks counter wrap.
module tb_mult_scheduler;

`ifdef MULT_SCHED_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, rsp_ready;
  logic [2:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready, rsp_valid, rsp_id;
  logic [5:0] rsp_p;
  logic [7:0] op_count;
  logic       req0_ready2, req1_ready2, rsp_valid2, rsp_id2;
  logic [5:0] rsp_p2;
  logic [1:0] op_count2;

  always #5 clk = ~clk;

  mult_scheduler #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p), .rsp_id(rsp_id),
    .op_count(op_count)
  );

  mult_scheduler #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready2),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_p(rsp_p2), .rsp_id(rsp_id2),
    .op_count(op_count2)
  );

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: m_stage 0 = free, 1 = product being formed (hidden), 2 = response visible.
  int m_stage = 0;
  bit m_last  = 1'b1;
  int m_p = 0, m_id = 0, m_cnt = 0;
  int pend_p = 0, pend_id = 0;
  int g_q[$];
  int r_p[$];
  int r_id[$];

  always @(negedge clk) begin
    bit er0, er1;
    int ga, gb;
    er0 = !rst && m_stage == 0 && req0_valid && (!req1_valid || m_last);
    er1 = !rst && m_stage == 0 && req1_valid && (!req0_valid || !m_last);
    if (chk_en) begin
      chk("req0_ready", int'(req0_ready), int'(er0));
      chk("req1_ready", int'(req1_ready), int'(er1));
      chk("rsp_valid", int'(rsp_valid), int'(m_stage == 2));
      chk("rsp_valid_w2", int'(rsp_valid2), int'(m_stage == 2));
      chk("op_count", int'(op_count), m_cnt % 256);
      chk("op_count_w2", int'(op_count2), m_cnt % 4);
      if (m_stage == 2) begin
        chk("rsp_p", int'(rsp_p), m_p);
        chk("rsp_id", int'(rsp_id), m_id);
        chk("rsp_p_w2", int'(rsp_p2), m_p);
      end
      if (req0_valid && req0_ready) g_q.push_back(0);
      if (req1_valid && req1_ready) g_q.push_back(1);
      if (rsp_valid && rsp_ready && !rst) begin
        r_p.push_back(int'(rsp_p));
        r_id.push_back(int'(rsp_id));
        $display("txn: id=%0d p=%0d op_count_before=%0d", rsp_id, rsp_p, op_count);
      end
    end
    // advance the model across the coming rising edge
    if (rst) begin
      m_stage = 0; m_last = 1'b1; m_p = 0; m_id = 0; m_cnt = 0;
    end else if (m_stage == 2) begin
      if (rsp_ready) begin
        m_stage = 0;
        m_cnt++;
      end
    end else if (m_stage == 1) begin
      m_stage = 2; m_p = pend_p; m_id = pend_id;
    end else if (er0 || er1) begin
      ga = er1 ? int'(req1_a) : int'(req0_a);
      gb = er1 ? int'(req1_b) : int'(req0_b);
      pend_id = er1 ? 1 : 0;
      pend_p  = ga * gb;
      m_last  = er1;
      if (BYP && (ga == 0 || gb == 0)) begin
        m_stage = 2; m_p = 0; m_id = pend_id;
      end else begin
        m_stage = 1;
      end
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = 3'd0; req0_b = 3'd0; req1_a = 3'd0; req1_b = 3'd0;
  endtask

  task automatic do_reset;
    cyc;
    rst = 1'b1;
    clear_inputs();
    cyc;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    cyc;
    chk_en = 1'b1;
    // reset still asserted with a requester waiting: no grant, idle outputs
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("rst_req0_ready", int'(req0_ready), 0);
    chk("rst_req1_ready", int'(req1_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_op_count", int'(op_count), 0);
    cyc;
    rst = 1'b0;
    clear_inputs();

    // 5*3 from requester 0, consumer always ready
    req0_valid = 1'b1; req0_a = 3'd5; req0_b = 3'd3; rsp_ready = 1'b1;
    @(negedge clk); chk("t1_accept", int'(req0_ready), 1);
    cyc; req0_valid = 1'b0; req0_a = 3'd7;
    @(negedge clk); chk("t1_n1_valid", int'(rsp_valid), 0);
    cyc;
    @(negedge clk);
    chk("t1_n2_valid", int'(rsp_valid), 1);
    chk("t1_p", int'(rsp_p), 15);
    chk("t1_id", int'(rsp_id), 0);
    cyc;
    @(negedge clk);
    chk("t1_count", int'(op_count), 1);
    chk("t1_valid_clr", int'(rsp_valid), 0);

    // both requesters valid continuously: grants alternate starting with 0
    do_reset();
    g_q.delete(); r_p.delete(); r_id.delete();
    req0_valid = 1'b1; req0_a = 3'd2; req0_b = 3'd3;
    req1_valid = 1'b1; req1_a = 3'd4; req1_b = 3'd5;
    rsp_ready = 1'b1;
    repeat (12) cyc;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_grant%0d", i), (g_q.size() > i) ? g_q[i] : -1, i % 2);
      chk($sformatf("t2_p%0d", i), (r_p.size() > i) ? r_p[i] : -1, (i % 2 == 0) ? 6 : 20);
      chk($sformatf("t2_id%0d", i), (r_id.size() > i) ? r_id[i] : -1, i % 2);
    end

    // 7*7 held under backpressure for five cycles while requester 1 waits
    do_reset();
    req0_valid = 1'b1; req0_a = 3'd7; req0_b = 3'd7;
    cyc; req0_valid = 1'b0; req1_valid = 1'b1; req1_a = 3'd1; req1_b = 3'd2;
    cyc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", int'(rsp_valid), 1);
      chk("t3_hold_p", int'(rsp_p), 49);
      chk("t3_hold_r0", int'(req0_ready), 0);
      chk("t3_hold_r1", int'(req1_ready), 0);
      cyc;
    end
    rsp_ready = 1'b1;
    @(negedge clk); chk("t3_done_valid", int'(rsp_valid), 1);
    cyc;
    @(negedge clk);
    chk("t3_after_valid", int'(rsp_valid), 0);
    chk("t3_after_count", int'(op_count), 1);
    chk("t3_next_grant", int'(req1_ready), 1);

    // reset while holding a result drops it; next request served normally
    do_reset();
    req0_valid = 1'b1; req0_a = 3'd3; req0_b = 3'd2;
    cyc; req0_valid = 1'b0;
    cyc;
    @(negedge clk); chk("t4_holding", int'(rsp_valid), 1);
    cyc; rst = 1'b1; req1_valid = 1'b1; req1_a = 3'd6; req1_b = 3'd6;
    @(negedge clk); chk("t4_rst_ready", int'(req1_ready), 0);
    cyc; rst = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_dropped", int'(rsp_valid), 0);
    chk("t4_count", int'(op_count), 0);
    chk("t4_accept", int'(req1_ready), 1);
    cyc; req1_valid = 1'b0;
    cyc;
    @(negedge clk);
    chk("t4_p", int'(rsp_p), 36);
    chk("t4_id", int'(rsp_id), 1);
    cyc;
    @(negedge clk); chk("t4_count_after", int'(op_count), 1);

    // zero operand: visible at N+1 with bypass, N+2 without
    do_reset();
    req1_valid = 1'b1; req1_a = 3'd0; req1_b = 3'd6;
    cyc; req1_valid = 1'b0;
    @(negedge clk); chk("t5_n1_valid", int'(rsp_valid), int'(BYP));
    cyc;
    @(negedge clk);
    chk("t5_n2_valid", int'(rsp_valid), 1);
    chk("t5_p", int'(rsp_p), 0);
    chk("t5_id", int'(rsp_id), 1);
    cyc; rsp_ready = 1'b1;
    cyc;
    @(negedge clk); chk("t5_count", int'(op_count), 1);

    // five back-to-back transactions with operands changing every cycle
    do_reset();
    req0_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      req0_a = 3'($urandom_range(1, 7));
      req0_b = 3'($urandom_range(1, 7));
      cyc;
    end
    req0_valid = 1'b0;
    @(negedge clk);
    chk("t6_count8", int'(op_count), 5);
    chk("t6_count2_wrap", int'(op_count2), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mult_scheduler.md
MULT_SCHEDULER -- requirements
Module: mult_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the completed-operation counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports req0_valid/req1_valid, input, 1 each, requester n has an operand pair pending.
REQ-005 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, 3 each, unsigned operands.
REQ-006 SHALL have ports req0_ready/req1_ready, output, 1 each, operand pair accepted this cycle when valid && ready.
REQ-007 SHALL have port rsp_valid, output, 1, result held on rsp_p/rsp_id.
REQ-008 SHALL have port rsp_ready, input, 1, consumer takes the result when rsp_valid && rsp_ready.
REQ-009 SHALL have ports rsp_p, output, 6, the product; rsp_id, output, 1, index of the requester that issued it.
REQ-010 SHALL have port op_count, output, CNT_W, number of responses consumed, modulo 2^CNT_W.

Function
REQ-011 SHALL own one shared 3x3 unsigned multiplier, product 6 bits (max 7*7=49), with no truncation.
REQ-012 SHALL implement a FSM with states IDLE, MUL and HOLD, with IDLE as the reset state.
REQ-013 SHALL drive readys only in IDLE: req0_ready = req0_valid && (!req1_valid || last==1); req1_ready = req1_valid && (!req0_valid || last==0); both readys 0 in MUL/HOLD.
REQ-014 SHALL keep the round-robin pointer last at the id of the most recent grant, reset to 1 so that req0 wins the first contention.
REQ-015 SHALL, on acceptance in IDLE, latch a, b and id, update last, and go to MUL.
REQ-016 SHALL, in MUL, register the product into rsp_p, set rsp_valid=1, and go to HOLD; acceptance in cycle N gives rsp_valid in cycle N+2.
REQ-017 SHALL, in HOLD, keep rsp_p, rsp_id and rsp_valid stable until rsp_ready=1, then clear rsp_valid, increment op_count and go to IDLE.
REQ-018 SHALL allow at most one transaction in flight; the next acceptance occurs no earlier than the cycle after the response is consumed.
REQ-019 SHALL ignore operand changes on any requester while it is not being accepted.
REQ-020 SHALL let op_count wrap from 2^CNT_W-1 to 0 with no flag.
REQ-021 SHALL leave last unchanged when only one requester is valid and is granted, apart from setting it to that id.

Reset
REQ-022 SHALL, when rst=1 at a clock edge, set state=IDLE, rsp_valid=0, rsp_p=0, rsp_id=0, op_count=0 and last=1.
REQ-023 SHALL drop a transaction interrupted by reset in MUL or HOLD, produce no response for it, and not count it.
REQ-024 SHALL hold req0_ready and req1_ready at 0 during any cycle with rst=1.

Configuration
REQ-025 SHALL, with macro MULT_SCHED_ZERO_BYPASS_EN defined, move an accepted pair with a==0 or b==0 directly from IDLE to HOLD with rsp_p=0 and rsp_valid in cycle N+1, skipping MUL.
REQ-026 SHALL, without MULT_SCHED_ZERO_BYPASS_EN, use the uniform two-cycle latency of REQ-016 for all operands.

Verification
REQ-027 SHALL verify: after reset, req0 a=5 b=3 and rsp_ready=1 -> rsp_valid two cycles after acceptance, rsp_p=15, rsp_id=0, op_count=1.
REQ-028 SHALL verify: req0 and req1 both valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1, and products match each requester's operands.
REQ-029 SHALL verify: a=7 b=7, rsp_ready held 0 for 5 cycles -> rsp_valid=1 and rsp_p=49 stable throughout, both readys 0, and completion on the cycle rsp_ready rises.
REQ-030 SHALL verify: rst asserted while in HOLD -> next cycle rsp_valid=0 and op_count unchanged from 0; the following request is served normally.
REQ-031 SHALL verify: a=0 b=6 -> rsp_p=0 at N+1 with MULT_SCHED_ZERO_BYPASS_EN and at N+2 without; CNT_W=2 with 5 transactions -> op_count=1.
